// File: rtl/ppa_mw_seq.sv
// ppa_mw_seq: WORDS x 16-bit add/subtract sequencer that reuses one 16-bit PPA adder,
// one slice per cycle, LSW first. Define PPA_SEQ_ZERO_FLAG_EN to add the 'zero' result flag.

module PPA (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [16:0] res_s;

  assign res_s = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
  assign s     = res_s[15:0];
  assign co    = res_s[16];

endmodule

module ppa_mw_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  output logic                ready,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
`ifdef PPA_SEQ_ZERO_FLAG_EN
  ,
  output logic                zero
`endif
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;
`ifdef PPA_SEQ_ZERO_FLAG_EN
  logic            zero_acc_r;
`endif

  logic            accept_s;
  logic            last_s;
  logic [15:0]     a_sl_s;
  logic [15:0]     b_sl_s;
  logic [15:0]     s_s;
  logic            co_s;

  // ready is high exactly in IDLE and DONE, so this is the only legal accept
  assign accept_s = start & ready;
  assign last_s   = (idx_r == IW'(WORDS - 1));
  assign a_sl_s   = a_r[{idx_r, 4'h0} +: 16];
  assign b_sl_s   = b_r[{idx_r, 4'h0} +: 16];

  PPA u_ppa (
    .a  (a_sl_s),
    .b  (b_sl_s),
    .ci (carry_r),
    .s  (s_s),
    .co (co_s)
  );

  // Sequencer FSM: latches operands on accept, walks slices LSW first, flags completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {IW{1'b0}};
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      carry_r    <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      sum        <= {W{1'b0}};
      cout       <= 1'b0;
      ovf        <= 1'b0;
`ifdef PPA_SEQ_ZERO_FLAG_EN
      zero_acc_r <= 1'b0;
      zero       <= 1'b0;
`endif
    end else if (accept_s) begin
      // subtraction is A + ~B + 1, so the inversion and forced carry happen here
      state_r    <= RUN;
      idx_r      <= {IW{1'b0}};
      a_r        <= a;
      b_r        <= sub ? ~b : b;
      carry_r    <= sub | cin;
      ready      <= 1'b0;
      done       <= 1'b0;
`ifdef PPA_SEQ_ZERO_FLAG_EN
      zero_acc_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
        end
        RUN: begin
          sum[{idx_r, 4'h0} +: 16] <= s_s;
          carry_r                  <= co_s;
`ifdef PPA_SEQ_ZERO_FLAG_EN
          zero_acc_r               <= zero_acc_r & (s_s == 16'h0000);
`endif
          if (last_s) begin
            state_r <= DONE;
            idx_r   <= {IW{1'b0}};
            done    <= 1'b1;
            ready   <= 1'b1;
            cout    <= co_s;
            // the MSW adder output is the final sign bit of the result
            ovf     <= (a_r[W-1] == b_r[W-1]) && (s_s[15] != a_r[W-1]);
`ifdef PPA_SEQ_ZERO_FLAG_EN
            zero    <= zero_acc_r & (s_s == 16'h0000);
`endif
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppa_mw_seq.sv
// Randomized self-checking bench for ppa_mw_seq (WORDS=4) against a full-width arithmetic model.
// Checks the zero flag when PPA_SEQ_ZERO_FLAG_EN is defined.

module tb_ppa_mw_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef PPA_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] e_sum;
  logic         e_cout;
  logic         e_ovf;
  logic         e_zero;

  ppa_mw_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
`ifdef PPA_SEQ_ZERO_FLAG_EN
    ,
    .zero  (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Drive a request at the current negedge and compute the expected result at full width
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic isub, input logic icin);
    logic [W:0] full;
    a     = ia;
    b     = ib;
    sub   = isub;
    cin   = icin;
    start = 1'b1;
    check("ready_at_req", ready, 1);
    if (isub) full = {1'b0, ia} - {1'b0, ib} + {1'b1, {W{1'b0}}};
    else      full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
    e_sum  = full[W-1:0];
    e_cout = full[W];
    if (isub) e_ovf = (ia[W-1] != ib[W-1]) && (e_sum[W-1] != ia[W-1]);
    else      e_ovf = (ia[W-1] == ib[W-1]) && (e_sum[W-1] != ia[W-1]);
    e_zero = (e_sum == {W{1'b0}});
  endtask

  // Wait (bounded) for done after the accept edge, checking latency and results
  task automatic complete(input bit busy_poke);
    int lat  = 0;
    bit seen = 1'b0;
    @(posedge clk);
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a     = rnd64();
        b     = rnd64();
        cin   = 1'($urandom_range(1));
        sub   = 1'($urandom_range(1));
        check("busy_ready", ready, 0);
      end
      if (busy_poke && lat == 2) begin
        start = 1'b1;
        a     = rnd64();
        b     = rnd64();
      end
      if (busy_poke && lat == 3) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("latency", lat, WORDS + 1);
    check("sum", sum, e_sum);
    check("cout", cout, e_cout);
    check("ovf", ovf, e_ovf);
    check("ready_done", ready, 1);
`ifdef PPA_SEQ_ZERO_FLAG_EN
    check("zero", zero, e_zero);
`endif
  endtask

  task automatic hold_check();
    @(negedge clk);
    check("done_pulse", done, 0);
    check("sum_hold", sum, e_sum);
    check("cout_hold", cout, e_cout);
    check("ready_idle", ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = {W{1'b0}};
    b     = {W{1'b0}};
    #12;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0); complete(1'b0); hold_check();
    issue(64'h0, 64'h1, 1'b1, 1'b1);                   complete(1'b0); hold_check();
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0); complete(1'b0); hold_check();
    issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0); complete(1'b0); hold_check();

    // back-to-back: second request accepted straight out of DONE
    issue(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1); complete(1'b0);
    issue(64'h5, 64'h3, 1'b1, 1'b0); complete(1'b0); hold_check();

    issue(rnd64(), rnd64(), 1'b0, 1'b0); complete(1'b1); hold_check();

    // abort in the third RUN cycle
    issue(rnd64(), rnd64(), 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WORDS + 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    issue(64'h2, 64'h2, 1'b0, 1'b0); complete(1'b0); hold_check();

    for (int i = 0; i < 30; i++) begin
      issue(rnd64(), rnd64(), 1'($urandom_range(1)), 1'($urandom_range(1)));
      complete(1'b0);
      if ($urandom_range(1) == 0) hold_check();
    end
    hold_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
